// File: rtl/ice_cream_dispenser.sv
// Scoop dispenser: turns order-level changes from the vending FSM into a queue of
// owed balls and paces the motor through scoop/gap timing while a cup is present.
module ice_cream_dispenser #(
  parameter int unsigned SCOOP_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] ice_cream_balls,
  input  logic       cup_present,
  output logic       motor_on,
  output logic       busy,
  output logic [2:0] pending,
  output logic [7:0] balls_served,
  output logic       scoop_done,
  output logic       overflow
);

  localparam int unsigned TIMER_W = 4;
  localparam int unsigned SUM_W   = 4;
  localparam int unsigned PEND_W  = 3;
  localparam logic [PEND_W-1:0] PEND_MAX = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCOOP = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [TIMER_W-1:0]   timer, timer_next;
  logic [1:0]           prev_balls, prev_next;
  logic [PEND_W-1:0]    pending_next;
  logic [7:0]           served_next;
  logic                 overflow_next;
  logic                 motor_next;
  logic                 busy_next;
  logic                 done;
  logic [1:0]           order_n;
  logic [SUM_W-1:0]     sum;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= '0;
      prev_balls   <= '0;
      pending      <= '0;
      balls_served <= '0;
      overflow     <= 1'b0;
      motor_on     <= 1'b0;
      scoop_done   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_next;
      timer        <= timer_next;
      prev_balls   <= prev_next;
      pending      <= pending_next;
      balls_served <= served_next;
      overflow     <= overflow_next;
      motor_on     <= motor_next;
      scoop_done   <= done;
      busy         <= busy_next;
    end
  end

  // Next-state, order detection and pending accounting
  always_comb begin
    state_next    = state;
    timer_next    = timer;
    done          = 1'b0;
    order_n       = 2'd0;
    prev_next     = prev_balls;
    sum           = '0;
    pending_next  = pending;
    overflow_next = overflow;
    served_next   = balls_served;
    motor_next    = 1'b0;
    busy_next     = 1'b0;

    unique case (state)
      IDLE: begin
        if (pending != '0 && cup_present) begin
          state_next = SCOOP;
          timer_next = TIMER_W'(SCOOP_CYCLES);
        end
      end
      SCOOP: begin
        // A falling cup_present does not abort the ball already in progress
        if (timer <= TIMER_W'(1)) begin
          state_next = GAP;
          timer_next = TIMER_W'(GAP_CYCLES);
          done       = 1'b1;
        end else begin
          timer_next = timer - TIMER_W'(1);
        end
      end
      GAP: begin
        if (timer <= TIMER_W'(1)) begin
          if (pending != '0 && cup_present) begin
            state_next = SCOOP;
            timer_next = TIMER_W'(SCOOP_CYCLES);
          end else begin
            state_next = IDLE;
            timer_next = '0;
          end
        end else begin
          timer_next = timer - TIMER_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase

    // Only a changed level of 1 or 2 is a new order; 3 is treated as noise
    if ((ice_cream_balls == 2'd1 || ice_cream_balls == 2'd2) &&
        ice_cream_balls != prev_balls) begin
      order_n = ice_cream_balls;
    end
    if (ice_cream_balls != 2'd3) begin
      prev_next = ice_cream_balls;
    end

    sum = SUM_W'(pending) + SUM_W'(order_n);
    if (done && sum != '0) begin
      sum = sum - SUM_W'(1);
    end
    if (sum > SUM_W'(PEND_MAX)) begin
      pending_next  = PEND_MAX;
      overflow_next = 1'b1;
    end else begin
      pending_next = PEND_W'(sum);
    end

    if (done) begin
      served_next = balls_served + 8'd1;
    end

    motor_next = (state_next == SCOOP);
    busy_next  = (state_next != IDLE) || (pending_next != '0);
  end

endmodule

// File: doc/ice_cream_dispenser.md
ICE_CREAM_DISPENSER -- requirements
Module: ice_cream_dispenser

Interface
REQ-001 Parameter SCOOP_CYCLES, default 4, number of cycles motor_on is held per ball (legal 1..15).
REQ-002 Parameter GAP_CYCLES, default 2, number of motor-off cycles after each ball (legal 1..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ice_cream_balls  input  2  order level from the upstream vending FSM (0 = none, 1 or 2 = balls owed, 3 = invalid).
REQ-006 cup_present  input  1  high when a cup is under the nozzle.
REQ-007 motor_on  output  1  scoop motor drive.
REQ-008 busy  output  1  high when state is not IDLE or pending is nonzero.
REQ-009 pending  output  3  balls ordered but not yet served.
REQ-010 balls_served  output  8  total balls served since reset.
REQ-011 scoop_done  output  1  one-cycle pulse per completed ball.
REQ-012 overflow  output  1  sticky flag, orders were dropped.

Function
REQ-013 Block SHALL register the last valid ice_cream_balls value in prev_balls (reset 0); value 3 SHALL be ignored and SHALL NOT update prev_balls.
REQ-014 An order of n balls SHALL be detected on an edge where ice_cream_balls is 1 or 2 and differs from prev_balls; a held level SHALL NOT re-trigger.
REQ-015 A change 2->1 SHALL count as a new order of 1; a change to 0 SHALL only update prev_balls.
REQ-016 pending SHALL update as pending + n - d, where n = detected order (0..2) and d = 1 on a scoop-completion edge, else 0.
REQ-017 If that sum exceeds 7, pending SHALL saturate at 7 and overflow SHALL set and stay set until reset.
REQ-018 FSM states SHALL be IDLE, SCOOP, GAP, encoded in 2 bits.
REQ-019 IDLE: if pending > 0 and cup_present = 1, go to SCOOP and load timer with SCOOP_CYCLES; otherwise stay.
REQ-020 SCOOP: motor_on = 1 every cycle; timer decrements; on the edge ending the last cycle, go to GAP, load GAP_CYCLES, apply d = 1, and increment balls_served (mod 256).
REQ-021 cup_present dropping during SCOOP SHALL NOT abort the current ball.
REQ-022 scoop_done SHALL be high exactly in the first GAP cycle after each scoop.
REQ-023 GAP: motor_on = 0; after GAP_CYCLES cycles, go to SCOOP if pending > 0 and cup_present, else IDLE.
REQ-024 Latency: with the FSM in IDLE and cup present, an order sampled on edge E SHALL give pending nonzero after E and motor_on high from edge E+1 for exactly SCOOP_CYCLES cycles.
REQ-025 An order arriving on the same edge as a completion SHALL apply both in one update, per REQ-016.
REQ-026 motor_on SHALL be a registered decode of state; it SHALL never be high outside SCOOP.

Reset
REQ-027 While reset is high on an edge, the block SHALL set the following, irrespective of other inputs:
  - state = IDLE, timer = 0, prev_balls = 0, pending = 0;
  - balls_served = 0, overflow = 0, motor_on = 0, scoop_done = 0, busy = 0.
REQ-028 Reset asserted mid-SCOOP SHALL drop motor_on on that edge and discard pending balls.
REQ-029 An ice_cream_balls value that is nonzero when reset is released SHALL be detected as a new order on the first non-reset edge.

Verification
REQ-030 Bench SHALL cover the following scenarios:
  - Single ball: cup = 1; balls 0->1 held 10 cycles -> pending 1; motor_on high 4 cycles; scoop_done one pulse; balls_served = 1; then IDLE, busy = 0.
  - Two balls: balls 0->2 -> two 4-cycle motor bursts separated by 2 off cycles; balls_served = 2; pending sequence 2, 1, 0.
  - Change to nonzero: balls 2->1 while serving -> pending increments by 1; 3 balls total served; level hold causes no extra orders.
  - Cup gating and saturation:
    - cup = 0 with pending 2 -> motor stays off; cup = 1 -> serving starts next edge.
    - Four orders of 2 with no cup -> pending = 7, overflow = 1.
  - Reset mid-scoop: reset in SCOOP cycle 2 -> motor_on = 0, pending = 0, balls_served = 0 next cycle; value 3 on input -> no order.
